// File: rtl/ram_dp_clear_pkg.sv
// Shared types and helpers for the clearable simple-dual-port RAM.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/ram_dp_clear_if.sv
// User-side write/read/clear port bundle of ram_dp_clear.
interface ram_dp_clear_if #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 5
);

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  clear_req;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  busy;
  logic                  clear_done;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, clear_req,
    input  rd_data, rd_valid, busy, clear_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, clear_req,
    output rd_data, rd_valid, busy, clear_done
  );

endinterface

// File: rtl/ram_dp_clear_core.sv
// Reset-free storage array: one write port, one enabled registered read port.
module ram_sdp_core
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rd_q
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rd_q <= mem[raddr];
    end
  end

endmodule

// File: rtl/ram_dp_clear.sv
// Simple-dual-port RAM with write-first bypass and a hardware clear sweep
// that runs after every reset or on clear_req.
module ram_dp_clear
  import ram_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 4,
  parameter int unsigned           ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic           clk,
  input  logic           reset,
  ram_dp_clear_if.slave  bus
);

  localparam int unsigned           DEPTH    = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]   CLR_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   clr_cnt_q, clr_cnt_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  clear_done_q, clear_done_d;
  logic                  rd_seen_q, rd_seen_d;
  logic                  byp_hit_q, byp_hit_d;
  logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  rd_accept;
  logic [DATA_WIDTH-1:0] core_rd;

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    rd_valid_d   = 1'b0;
    clear_done_d = 1'b0;
    rd_seen_d    = rd_seen_q;
    byp_hit_d    = byp_hit_q;
    byp_data_d   = byp_data_q;
    mem_we       = 1'b0;
    mem_waddr    = bus.wr_addr;
    mem_wdata    = bus.wr_data;
    rd_accept    = 1'b0;

    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q[ADDR_WIDTH-1:0];
        mem_wdata = INIT_VALUE;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CLR_LAST) begin
          state_d      = READY;
          clear_done_d = 1'b1;
        end
      end
      READY: begin
        mem_we    = bus.wr_en;
        rd_accept = bus.rd_en;
        if (bus.rd_en) begin
          rd_valid_d = 1'b1;
          rd_seen_d  = 1'b1;
          byp_hit_d  = bus.wr_en && (bus.wr_addr == bus.rd_addr);
          byp_data_d = bus.wr_data;
        end
        if (bus.clear_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
    endcase

    if (!reset) begin
      mem_we    = 1'b0;
      rd_accept = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= CLEAR;
      clr_cnt_q    <= '0;
      rd_valid_q   <= 1'b0;
      clear_done_q <= 1'b0;
      rd_seen_q    <= 1'b0;
      byp_hit_q    <= 1'b0;
      byp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      rd_valid_q   <= rd_valid_d;
      clear_done_q <= clear_done_d;
      rd_seen_q    <= rd_seen_d;
      byp_hit_q    <= byp_hit_d;
      byp_data_q   <= byp_data_d;
    end
  end

  ram_sdp_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_core (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (rd_accept),
    .raddr (bus.rd_addr),
    .rd_q  (core_rd)
  );

  // The array read register has no reset, so rd_data is rebuilt from it:
  // zero until the first accepted read, then bypass data or array data.
  assign bus.rd_data    = !rd_seen_q ? '0 : (byp_hit_q ? byp_data_q : core_rd);
  assign bus.rd_valid   = rd_valid_q;
  assign bus.busy       = (state_q == CLEAR);
  assign bus.clear_done = clear_done_q;

endmodule

// File: tb/tb_ram_dp_clear.sv
// Drives two RAM instances (INIT_VALUE 0 and 9) with identical stimulus and
// compares both against a behavioural model of the clearable RAM.
module tb_ram_dp_clear;

  localparam int DW    = 4;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          we, re, cr;
  logic [AW-1:0] wa, ra;
  logic [DW-1:0] wd;

  ram_dp_clear_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifa ();
  ram_dp_clear_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifb ();

  assign ifa.wr_en     = we;
  assign ifa.wr_addr   = wa;
  assign ifa.wr_data   = wd;
  assign ifa.rd_en     = re;
  assign ifa.rd_addr   = ra;
  assign ifa.clear_req = cr;
  assign ifb.wr_en     = we;
  assign ifb.wr_addr   = wa;
  assign ifb.wr_data   = wd;
  assign ifb.rd_en     = re;
  assign ifb.rd_addr   = ra;
  assign ifb.clear_req = cr;

  ram_dp_clear #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_VALUE(4'h0)) dut_a (
    .clk(clk), .reset(rst), .bus(ifa.slave)
  );
  ram_dp_clear #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_VALUE(4'h9)) dut_b (
    .clk(clk), .reset(rst), .bus(ifb.slave)
  );

  // Behavioural model: one copy per instance
  logic [DW-1:0] mem_m  [2][DEPTH];
  int            left_m [2];
  bit            busy_m [2];
  bit            rdv_m  [2];
  bit            cd_m   [2];
  logic [DW-1:0] rdd_m  [2];
  logic [DW-1:0] iv     [2];

  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        busy_m[k] = 1'b1;
        left_m[k] = DEPTH;
        rdd_m[k]  = '0;
        rdv_m[k]  = 1'b0;
        cd_m[k]   = 1'b0;
      end else if (busy_m[k]) begin
        mem_m[k][DEPTH - left_m[k]] = iv[k];
        left_m[k]--;
        rdv_m[k] = 1'b0;
        cd_m[k]  = (left_m[k] == 0);
        if (left_m[k] == 0) busy_m[k] = 1'b0;
      end else begin
        cd_m[k]  = 1'b0;
        rdv_m[k] = re;
        if (re) rdd_m[k] = (we && wa == ra) ? wd : mem_m[k][ra];
        if (we) mem_m[k][wa] = wd;
        if (cr) begin
          busy_m[k] = 1'b1;
          left_m[k] = DEPTH;
        end
      end
    end
  endtask

  task automatic check_outs(input string tag);
    chk($sformatf("%s.a.busy", tag),       ifa.busy,       busy_m[0]);
    chk($sformatf("%s.a.rd_valid", tag),   ifa.rd_valid,   rdv_m[0]);
    chk($sformatf("%s.a.clear_done", tag), ifa.clear_done, cd_m[0]);
    chk($sformatf("%s.a.rd_data", tag),    ifa.rd_data,    rdd_m[0]);
    chk($sformatf("%s.b.busy", tag),       ifb.busy,       busy_m[1]);
    chk($sformatf("%s.b.rd_valid", tag),   ifb.rd_valid,   rdv_m[1]);
    chk($sformatf("%s.b.clear_done", tag), ifb.clear_done, cd_m[1]);
    chk($sformatf("%s.b.rd_data", tag),    ifb.rd_data,    rdd_m[1]);
  endtask

  task automatic step(input bit r, input bit w, input logic [AW-1:0] aw_i,
                      input logic [DW-1:0] d_i, input bit rd, input logic [AW-1:0] ar_i,
                      input bit c, input string tag);
    rst = r; we = w; wa = aw_i; wd = d_i; re = rd; ra = ar_i; cr = c;
    @(posedge clk);
    model_edge();
    #1;
    check_outs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) step(1, 0, '0, '0, 0, '0, 0, tag);
  endtask

  task automatic rd(input logic [AW-1:0] a, input string tag);
    step(1, 0, '0, '0, 1, a, 0, tag);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
    step(1, 1, a, d, 0, '0, 0, tag);
  endtask

  int n;

  initial begin
    iv[0] = 4'h0;
    iv[1] = 4'h9;
    rst = 1'b0; we = 1'b0; re = 1'b0; cr = 1'b0; wa = '0; ra = '0; wd = '0;

    // 1: reset for two edges, then a full sweep of exactly 32 edges
    step(0, 0, '0, '0, 0, '0, 0, "s1.rst");
    step(0, 0, '0, '0, 0, '0, 0, "s1.rst");
    n = 0;
    while (ifa.busy && n < 100) begin
      idle(1, "s1.sweep");
      n++;
    end
    chk("s1.busy_edges", n, 32);
    chk("s1.done_pulse", ifa.clear_done, 1'b1);
    rd(5'd0,  "s1.rd0");
    chk("s1.rd0.a", ifa.rd_data, 4'h0);
    chk("s1.rd0.b", ifb.rd_data, 4'h9);
    rd(5'd15, "s1.rd15");
    rd(5'd31, "s1.rd31");
    chk("s1.rd31.b", ifb.rd_data, 4'h9);
    idle(1, "s1.idle");

    // 2: write then read back
    wr(5'd1, 4'h1, "s2.wr");
    wr(5'd2, 4'h2, "s2.wr");
    wr(5'd3, 4'h3, "s2.wr");
    wr(5'd31, 4'hF, "s2.wr");
    rd(5'd1, "s2.rd1");
    rd(5'd2, "s2.rd2");
    rd(5'd3, "s2.rd3");
    rd(5'd31, "s2.rd31");
    chk("s2.rd31.a", ifa.rd_data, 4'hF);
    idle(2, "s2.hold");
    chk("s2.hold.a", ifa.rd_data, 4'hF);

    // 3: same-address read during write returns the new data
    step(1, 1, 5'd7, 4'hA, 1, 5'd7, 0, "s3.byp");
    chk("s3.byp.a", ifa.rd_data, 4'hA);
    rd(5'd7, "s3.rd7");
    chk("s3.rd7.b", ifb.rd_data, 4'hA);

    // 4: clear request; writes and reads during the sweep are dropped
    step(1, 0, '0, '0, 0, '0, 1, "s4.req");
    n = 0;
    while (ifa.busy && n < 100) begin
      step(1, (n == 0), 5'd2, 4'h5, 1, AW'($urandom_range(0, 31)), 0, "s4.sweep");
      n++;
    end
    chk("s4.busy_edges", n, 32);
    rd(5'd2, "s4.rd2");
    chk("s4.rd2.a", ifa.rd_data, 4'h0);
    rd(5'd31, "s4.rd31");
    chk("s4.rd31.b", ifb.rd_data, 4'h9);

    // 5: reset mid-sweep restarts it; clear_req mid-sweep does not extend it
    step(1, 0, '0, '0, 0, '0, 1, "s5.req");
    idle(10, "s5.part");
    step(0, 0, '0, '0, 0, '0, 0, "s5.rst");
    n = 0;
    while (ifa.busy && n < 100) begin
      step(1, 0, '0, '0, 0, '0, (n == 5), "s5.sweep");
      n++;
    end
    chk("s5.busy_edges", n, 32);
    rd(5'd10, "s5.rd10");

    // Randomized traffic with occasional clears and resets
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] r_a;
      logic [AW-1:0] w_a;
      r_a = AW'($urandom_range(0, 31));
      w_a = ($urandom_range(0, 3) == 0) ? r_a : AW'($urandom_range(0, 31));
      step(($urandom_range(0, 199) != 0), $urandom_range(0, 1) == 1, w_a,
           DW'($urandom_range(0, 15)), $urandom_range(0, 1) == 1, r_a,
           ($urandom_range(0, 49) == 0), "rnd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ram_dp_clear.md
Name: ram_dp_clear

Overview:
- Parametrised simple-dual-port synchronous RAM. It is the next generation of the board-level 32x4 RAM used in the lab top levels.
- It has independent write and read ports, a registered read with a valid flag, and a same-cycle read-during-write bypass.
- A hardware clear sequencer sweeps every word to INIT_VALUE after reset or on request. The memory array itself carries no reset, so it stays inferable as block RAM.
- It sits between the switch/KEY input logic and the seg7 display path, and can be reused as FIFO storage.

Parameters:
- DATA_WIDTH, 4, width of each word in bits.
- ADDR_WIDTH, 5, address width in bits; DEPTH = 2**ADDR_WIDTH words.
- INIT_VALUE, 0, value (DATA_WIDTH bits) written to every word by the clear sequence.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_WIDTH  read address.
- clear_req  in  1  request a full clear; honoured only in READY.
- rd_data  out  DATA_WIDTH  registered read data; holds its value between reads.
- rd_valid  out  1  high for exactly one cycle after an accepted read.
- busy  out  1  high while in CLEAR; all user reads and writes are ignored.
- clear_done  out  1  one-cycle pulse on the cycle busy falls.

Behaviour:
- Reset (reset==0 at an edge):
  - state<=CLEAR, clr_cnt<=0, rd_data<=0, rd_valid<=0, clear_done<=0.
  - busy is combinational (state==CLEAR), so it is high from the first reset edge onward.
- Two FSM states, CLEAR and READY:
  - CLEAR: each edge writes mem[clr_cnt]<=INIT_VALUE and increments clr_cnt.
  - When clr_cnt==DEPTH-1, state<=READY and clear_done<=1 for one cycle.
  - The sweep therefore takes exactly DEPTH edges after reset releases. busy is low after the DEPTH-th edge.
  - READY: if clear_req==1, state<=CLEAR and clr_cnt<=0. A write or read accepted on that same edge completes normally.
- clear_req during CLEAR is ignored; it neither restarts nor extends the sweep.
- A reset asserted mid-clear restarts the sweep from address 0.
- Write, READY only: if wr_en, mem[wr_addr]<=wr_data on the edge. wr_en in CLEAR is dropped, with no queuing.
- Read, READY only:
  - Accepted when rd_en==1. On the edge, rd_data<=mem[rd_addr] and rd_valid<=1. Latency is 1 cycle.
  - rd_en==0, or any cycle in CLEAR: rd_valid<=0 and rd_data holds its last value.
- Read-during-write, same address, same edge: rd_data returns the new wr_data (write-first bypass). Different addresses are independent.
- Addresses are full-range by construction, so no out-of-range case exists.
- clr_cnt is ADDR_WIDTH+1 bits wide to avoid wrap ambiguity. Only the low ADDR_WIDTH bits index the memory.
- The memory contents are undefined before the first sweep completes. The sweep runs on every reset, so user logic never sees undefined data.

Decomposition:
- Package ram_pkg:
  - state enum typedef {CLEAR, READY}.
  - Helper function for DEPTH.
- Sub-module ram_sdp_core:
  - Plain parametrised array with one write port and one registered read port, no reset.
  - Muxing of the clear address/data versus the user write, and the bypass compare, live in ram_dp_clear.

Test Plan (DATA_WIDTH=4, ADDR_WIDTH=5):
1. Hold reset=0 for 2 edges, then release. busy must stay high for exactly 32 edges; clear_done pulses on edge 32. Then reading addresses 0, 15 and 31 gives rd_data=0 with rd_valid=1, one cycle after each rd_en.
2. Write 1 to address 1, 2 to 2, 3 to 3 and 4'hF to 31, then read them back in order. rd_data must be 1, 2, 3, F, each with one-cycle latency.
3. Same edge: wr_en=1, wr_addr=7, wr_data=4'hA, rd_en=1, rd_addr=7. Next cycle rd_data=A, rd_valid=1. A second read of address 7 also returns A.
4. After scenario 2, pulse clear_req. busy is high for 32 edges. A write of 4'h5 to address 2 issued during busy is dropped, and rd_valid stays 0 throughout. After the sweep, reading addresses 2 and 31 returns 0.
5. Assert reset=0 when clr_cnt=10 in a sweep, then release. busy lasts a full 32 edges from the release. A clear_req pulse mid-sweep does not extend busy.
6. Re-run scenario 1 with INIT_VALUE=4'h9. All read-back words must be 9. rd_data reads 0 only from reset until the first read.
